// File: rtl/lc_sweep_ctrl.sv
// Truth-table sweep sequencer: drives every input vector, waits a settle time,
// samples the circuit outputs and checks them against a golden table.
module lc_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 3,
    parameter int SETTLE = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [N_OUT*(2**N_IN)-1:0]     expect_vec,
    input  logic [N_OUT-1:0]               dut_out,
    output logic [N_IN-1:0]                dut_in,
    output logic                           busy,
    output logic                           cap_valid,
    output logic [N_IN-1:0]                cap_idx,
    output logic [N_OUT-1:0]               cap_data,
    output logic                           cap_match,
    output logic                           done,
    output logic                           pass,
    output logic [N_IN:0]                  fail_count,
    output logic [N_IN-1:0]                first_fail_idx
);

    // state  | meaning
    // IDLE   | waiting for start, results held
    // DRIVE  | current vector presented on dut_in
    // WAIT   | settle counter running down to zero
    // SAMPLE | compare dut_out against golden entry, advance or finish
    // FINISH | done pulse, final cap_valid, pass valid
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int              NVEC      = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX  = N_IN'(NVEC - 1);
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);

    state_t              state_q, state_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                cap_valid_q, cap_valid_d;
    logic [N_IN-1:0]     cap_idx_q, cap_idx_d;
    logic [N_OUT-1:0]    cap_data_q, cap_data_d;
    logic                cap_match_q, cap_match_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [N_IN:0]       fail_count_q, fail_count_d;
    logic [N_IN-1:0]     first_fail_q, first_fail_d;
    logic [N_OUT-1:0]    exp_entry;
    logic                hit;

    always_comb begin
        exp_entry    = expect_vec[int'(idx_q)*N_OUT +: N_OUT];
        hit          = (dut_out == exp_entry);
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        cap_valid_d  = 1'b0;
        cap_idx_d    = cap_idx_q;
        cap_data_d   = cap_data_q;
        cap_match_d  = cap_match_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;

        // Abort preempts everything, including a capture pending in SAMPLE.
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d      = DRIVE;
                        idx_d        = '0;
                        busy_d       = 1'b1;
                        fail_count_d = '0;
                        first_fail_d = '0;
                        pass_d       = 1'b0;
                    end
                end
                DRIVE: begin
                    state_d = WAIT;
                    cnt_d   = SETTLE_LD;
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                SAMPLE: begin
                    cap_valid_d = 1'b1;
                    cap_idx_d   = idx_q;
                    cap_data_d  = dut_out;
                    cap_match_d = hit;
                    if (!hit) begin
                        fail_count_d = fail_count_q + (N_IN+1)'(1);
                        if (fail_count_q == '0) begin
                            first_fail_d = idx_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        pass_d  = (fail_count_d == '0);
                    end else begin
                        state_d = DRIVE;
                        idx_d   = idx_q + N_IN'(1);
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            cap_valid_q  <= 1'b0;
            cap_idx_q    <= '0;
            cap_data_q   <= '0;
            cap_match_q  <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            cap_valid_q  <= cap_valid_d;
            cap_idx_q    <= cap_idx_d;
            cap_data_q   <= cap_data_d;
            cap_match_q  <= cap_match_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign dut_in         = idx_q;
    assign busy           = busy_q;
    assign cap_valid      = cap_valid_q;
    assign cap_idx        = cap_idx_q;
    assign cap_data       = cap_data_q;
    assign cap_match      = cap_match_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_lc_sweep_ctrl.sv
// Directed bench for lc_sweep_ctrl: table of full sweeps plus abort, async
// reset, back-to-back and SETTLE=5 sequences, against a 2-input logic model.
module tb_lc_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        start5 = 1'b0;
    logic [11:0] expect_vec = 12'hCD8;
    logic [2:0]  dut_out, dut_out5;
    logic [1:0]  dut_in, dut_in5;
    logic        busy, cap_valid, cap_match, done, pass;
    logic [1:0]  cap_idx, first_fail_idx;
    logic [2:0]  cap_data, fail_count;
    logic        busy5, cap_valid5, cap_match5, done5, pass5;
    logic [1:0]  cap_idx5, first_fail_idx5;
    logic [2:0]  cap_data5, fail_count5;

    always #5 clk = ~clk;

    function automatic logic [2:0] model(input logic [1:0] v);
        return {v[1] & v[0], v[1] | v[0], v[1] ^ v[0]};
    endfunction

    assign dut_out  = model(dut_in);
    assign dut_out5 = model(dut_in5);

    lc_sweep_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expect_vec(expect_vec), .dut_out(dut_out), .dut_in(dut_in),
        .busy(busy), .cap_valid(cap_valid), .cap_idx(cap_idx),
        .cap_data(cap_data), .cap_match(cap_match), .done(done),
        .pass(pass), .fail_count(fail_count), .first_fail_idx(first_fail_idx)
    );

    lc_sweep_ctrl #(.SETTLE(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .abort(1'b0),
        .expect_vec(expect_vec), .dut_out(dut_out5), .dut_in(dut_in5),
        .busy(busy5), .cap_valid(cap_valid5), .cap_idx(cap_idx5),
        .cap_data(cap_data5), .cap_match(cap_match5), .done(done5),
        .pass(pass5), .fail_count(fail_count5), .first_fail_idx(first_fail_idx5)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // cycle counter and capture monitor
    int         cyc = 0;
    int         cap_n = 0, cap_c_first = 0, cap_c_last = 0;
    int         done_n = 0, done_c0 = 0, done_c1 = 0;
    int         done5_n = 0, done5_c = 0;
    logic [1:0] cap_idx_a [8];
    logic [2:0] cap_data_a [8];
    logic       cap_match_a [8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cap_valid) begin
            if (cap_n < 8) begin
                cap_idx_a[cap_n]   = cap_idx;
                cap_data_a[cap_n]  = cap_data;
                cap_match_a[cap_n] = cap_match;
            end
            if (cap_n == 0) cap_c_first = cyc;
            cap_c_last = cyc;
            cap_n++;
        end
        if (done) begin
            if (done_n == 0) done_c0 = cyc;
            else if (done_n == 1) done_c1 = cyc;
            done_n++;
        end
        if (done5) begin
            done5_c = cyc;
            done5_n++;
        end
    end

    typedef struct {
        logic [11:0] ev;
        logic [3:0]  mask;
        int          fc;
        int          ff;
        logic        ps;
        int          extra;
    } vec_t;

    vec_t tbl [5];
    int   t0;

    task automatic run_sweep(input logic [11:0] ev, input int extra, output int lat);
        expect_vec = ev;
        cap_n = 0;
        done_n = 0;
        lat = -1;
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        for (int k = 1; k < 100; k++) begin
            @(posedge clk); #1;
            start = (extra != 0 && k == extra);
            if (done_n != 0) begin
                lat = done_c0 - t0;
                break;
            end
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        tbl[0] = '{12'hCD8, 4'b1111, 0, 0, 1'b1, 0};
        tbl[1] = '{12'hCDA, 4'b1110, 1, 0, 1'b0, 0};
        tbl[2] = '{12'h327, 4'b0000, 4, 0, 1'b0, 0};
        tbl[3] = '{12'hED8, 4'b0111, 1, 3, 1'b0, 0};
        tbl[4] = '{12'hCD8, 4'b1111, 0, 0, 1'b1, 6};

        #3 rst_n = 1'b0;
        #1;
        chk("rst dut_in", dut_in, 0);
        chk("rst busy", busy, 0);
        chk("rst cap_valid", cap_valid, 0);
        chk("rst cap_idx", cap_idx, 0);
        chk("rst cap_data", cap_data, 0);
        chk("rst cap_match", cap_match, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst fail_count", fail_count, 0);
        chk("rst first_fail_idx", first_fail_idx, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int t = 0; t < 5; t++) begin
            run_sweep(tbl[t].ev, tbl[t].extra, lat);
            chk($sformatf("sweep%0d latency", t), lat, 17);
            chk($sformatf("sweep%0d cap count", t), cap_n, 4);
            chk($sformatf("sweep%0d first cap cycle", t), cap_c_first - t0, 5);
            chk($sformatf("sweep%0d last cap with done", t), cap_c_last, done_c0);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sweep%0d v%0d cap_idx", t, i), cap_idx_a[i], i);
                chk($sformatf("sweep%0d v%0d cap_data", t, i), cap_data_a[i], model(2'(i)));
                chk($sformatf("sweep%0d v%0d cap_match", t, i), cap_match_a[i], tbl[t].mask[i]);
            end
            chk($sformatf("sweep%0d fail_count", t), fail_count, tbl[t].fc);
            if (tbl[t].fc != 0)
                chk($sformatf("sweep%0d first_fail_idx", t), first_fail_idx, tbl[t].ff);
            chk($sformatf("sweep%0d pass", t), pass, tbl[t].ps);
            chk($sformatf("sweep%0d done count", t), done_n, 1);
            chk($sformatf("sweep%0d idle busy", t), busy, 0);
        end

        // abort in WAIT of vector 2
        expect_vec = 12'hCD8;
        cap_n = 0;
        done_n = 0;
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc - t0 < 10 && cyc - t0 < 50) begin
            @(posedge clk); #1;
        end
        chk("abort pre dut_in", dut_in, 2);
        chk("abort pre busy", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort dut_in", dut_in, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort cap count", cap_n, 2);
        chk("abort no done", done_n, 0);
        chk("abort pass", pass, 0);
        chk("abort still idle", busy, 0);
        run_sweep(12'hCD8, 0, lat);
        chk("post-abort latency", lat, 17);
        chk("post-abort pass", pass, 1);

        // start+abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", busy, 0);

        // async reset in DRIVE of vector 1
        cap_n = 0;
        done_n = 0;
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc - t0 < 5 && cyc - t0 < 50) begin
            @(posedge clk); #1;
        end
        chk("pre-reset dut_in", dut_in, 1);
        chk("pre-reset cap_valid", cap_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async dut_in", dut_in, 0);
        chk("async busy", busy, 0);
        chk("async cap_valid", cap_valid, 0);
        chk("async cap_data", cap_data, 0);
        chk("async cap_match", cap_match, 0);
        chk("async fail_count", fail_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post-reset idle busy", busy, 0);
        chk("post-reset dut_in", dut_in, 0);
        chk("post-reset no done", done_n, 0);

        // back-to-back with start held high
        expect_vec = 12'hCD8;
        done_n = 0;
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 100 && done_n < 2; k++) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("b2b done count", done_n, 2);
        chk("b2b first latency", done_c0 - t0, 17);
        chk("b2b spacing", done_c1 - done_c0, 18);
        repeat (20) @(posedge clk);
        #1;

        // SETTLE = 5 instance
        done5_n = 0;
        @(posedge clk); #1;
        start5 = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start5 = 1'b0;
        for (int k = 0; k < 100 && done5_n == 0; k++) begin
            @(posedge clk); #1;
        end
        chk("settle5 done seen", done5_n, 1);
        chk("settle5 latency", done5_c - t0, 29);
        chk("settle5 pass", pass5, 1);
        chk("settle5 fail_count", fail_count5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lc_sweep_ctrl.md
# lc_sweep_ctrl

Exhaustive truth-table sweep controller for the small combinational logic circuits in `logic_circuits/`. On `start` it drives every input combination in turn onto the circuit under control, waits a settle interval, and samples the outputs. It compares each sample against a golden table supplied on `expect_vec` and reports per-vector captures plus a pass/fail summary. It replaces hand-written per-combination stimulus with a reusable, synthesizable sequencer.

## Interface
- `N_IN`, default 2: number of circuit inputs; the sweep covers 2^N_IN vectors.
- `N_OUT`, default 3: number of circuit outputs compared per vector.
- `SETTLE`, default 2: wait cycles between driving a vector and sampling; legal range is 1..15.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request, sampled only in IDLE.
- `abort`  in  1  cancels an active sweep.
- `expect_vec`  in  N_OUT·2^N_IN  golden table; entry i is at `[i*N_OUT +: N_OUT]`; must be held stable while `busy`.
- `dut_out`  in  N_OUT  outputs of the circuit under control.
- `dut_in`  out  N_IN  registered input vector driven to the circuit.
- `busy`  out  1  high from the DRIVE of vector 0 until the return to IDLE.
- `cap_valid`  out  1  one-cycle pulse per sampled vector.
- `cap_idx`  out  N_IN  index of the captured vector.
- `cap_data`  out  N_OUT  sampled `dut_out`.
- `cap_match`  out  1  `cap_data` equals the golden entry.
- `done`  out  1  one-cycle pulse on normal completion.
- `pass`  out  1  the last completed sweep had zero mismatches.
- `fail_count`  out  N_IN+1  number of mismatches in the current or last sweep.
- `first_fail_idx`  out  N_IN  index of the first mismatch; meaningful only when `fail_count` is nonzero.

## Operation
- The FSM has five states: IDLE, DRIVE, WAIT, SAMPLE, FINISH.
- IDLE:
  - With `start`=1 and `abort`=0, the next state is DRIVE.
  - On that transition: `idx`=0, `fail_count`=0, `first_fail_idx`=0, `pass`=0.
- DRIVE (1 cycle):
  - `dut_in` takes `idx` at the clock edge that enters DRIVE, so the vector is visible throughout DRIVE.
  - Next state is WAIT, with the settle counter loaded with `SETTLE`-1.
- WAIT (`SETTLE` cycles):
  - The counter decrements each cycle.
  - At 0 the next state is SAMPLE.
- SAMPLE (1 cycle):
  - Registers `dut_out` into `cap_data`, `idx` into `cap_idx`, and the comparison result into `cap_match`.
  - Pulses `cap_valid` in the following cycle.
  - On a mismatch, `fail_count` increments. If the old `fail_count` was 0, `first_fail_idx` is set to `idx`.
  - If `idx` = 2^N_IN−1, the next state is FINISH; otherwise `idx` increments and the next state is DRIVE.
- FINISH (1 cycle):
  - `done`=1.
  - `pass` is set to (final `fail_count` == 0), including the final vector's result.
  - Next state is IDLE.
- Result hold: `pass`, `fail_count`, `first_fail_idx` and the `cap_*` fields hold until the next accepted `start`.
- Index width: `idx` is N_IN bits with no wrap-around. The terminal check stops the sweep before overflow.
- `fail_count` width: N_IN+1 bits, so it can reach 2^N_IN without saturating.
- `start` while `busy`: ignored, no restart.
- `abort`:
  - In any state other than IDLE, it forces IDLE at the next edge.
  - `dut_in` is set to 0 and `busy` drops.
  - No `done` pulse; `pass` stays 0; `fail_count` keeps its partial value.
  - A `cap_valid` already scheduled from SAMPLE is suppressed.
- `start` and `abort` together in IDLE: `abort` wins and the sweep is not started.
- Async reset: may occur at any time. It takes effect immediately, regardless of state.

## Timing
- Reset values: state IDLE; `dut_in`=0, `busy`=0, `cap_valid`=0, `cap_idx`=0, `cap_data`=0, `cap_match`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_idx`=0.
- Cycle numbering: `start` is seen at edge 0.
  - Vector 0 is driven from edge 1.
  - It is sampled at edge 2+SETTLE.
  - Its `cap_valid` is high in the cycle after that edge.
- Cost per vector: 2+SETTLE cycles.
- Total latency from `start` to `done`: 2^N_IN·(2+SETTLE)+1 cycles. With the defaults this is 4·4+1 = 17.
- `busy` is high exactly from edge 1 through the FINISH cycle.
- `done` and the final `cap_valid` are asserted in the same cycle, FINISH.
- Back-to-back sweeps: a `start` held high at the return to IDLE is accepted one cycle after `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Clean sweep.** Defaults, a bench model computing `{a&b, a|b, a^b}`, `expect_vec`=12'hCD8, `start` pulse:
  - `cap_idx` sequence 0,1,2,3 with `cap_data` 000, 011, 011, 110, all with `cap_match`=1.
  - `done` 17 cycles after `start`; `pass`=1, `fail_count`=0.
- **Single fault.** As above, but `expect_vec`=12'hCDA (entry 0 = 010):
  - Vector 0 shows `cap_match`=0.
  - Final `fail_count`=1, `first_fail_idx`=0, `pass`=0.
- **All wrong.** `expect_vec`=12'h327 (every entry inverted):
  - `fail_count`=4, reaching the maximum without overflow.
  - `first_fail_idx`=0, `pass`=0.
- **Abort mid-sweep.** Assert `abort` in the WAIT state of vector 2:
  - Next cycle: IDLE, `busy`=0, `dut_in`=0.
  - No `done` pulse and no further `cap_valid`.
  - A following `start` completes a normal 17-cycle sweep.
- **Async reset mid-sweep.** Drop `rst_n` during DRIVE of vector 1:
  - All outputs reach their reset values without waiting for a clock edge.
  - After release, the block idles until `start`.
- **Ignored start / SETTLE variation.** Pulse `start` during `busy`:
  - No restart; `done` still arrives at cycle 17.
  - With SETTLE=5, `done` arrives at cycle 29.
